// File: rtl/counter_defs_pkg.sv
// Shared definitions for the team's counter blocks: default width,
// timer state encoding and timer mode encoding.
package counter_defs_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_RELOAD  = 1'b1
  } mode_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down counter/timer with one-shot or auto-reload operation and a
// registered one-cycle expiry pulse on terminal count.
module down_counter_timer
  import counter_defs_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             expire,
  output logic             busy
);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             expire_q, expire_d;
  logic             terminal;

  // Terminal count is the enabled RUN cycle that starts from 1, so the
  // counter never has to pass through 0 while reloading.
  assign terminal = (state_q == ST_RUN) && enable && (count_q == WIDTH'(1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    reload_d = reload_q;
    expire_d = 1'b0;

    if (load) begin
      count_d  = data;
      reload_d = data;
      mode_d   = mode_t'(mode);
      state_d  = (data != '0) ? ST_RUN : ST_IDLE;
    end else if (terminal) begin
      expire_d = 1'b1;
      if (mode_q == MODE_RELOAD) begin
        count_d = reload_q;
      end else begin
        count_d = '0;
        state_d = ST_IDLE;
      end
    end else if ((state_q == ST_RUN) && enable) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_ONESHOT;
      count_q  <= '0;
      reload_q <= '0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      expire_q <= expire_d;
    end
  end

  assign count  = count_q;
  assign zero   = (count_q == '0);
  assign expire = expire_q;
  assign busy   = (state_q == ST_RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: vector table, directed corner
// sequences and a randomized run against a behavioural timer model.
module tb_down_counter_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         load;
  logic         mode;
  logic [W-1:0] data;
  logic [W-1:0] count;
  logic         zero;
  logic         expire;
  logic         busy;

  int total = 0;
  int bad   = 0;

  down_counter_timer #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .load   (load),
    .mode   (mode),
    .data   (data),
    .count  (count),
    .zero   (zero),
    .expire (expire),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         load;
    logic         mode;
    logic [W-1:0] data;
    logic         enable;
    logic [W-1:0] exp_count;
    logic         exp_expire;
    logic         exp_busy;
    logic         exp_zero;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: remaining count, period and a running flag.
  int m_count, m_reload;
  bit m_mode, m_running, m_expire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input logic md, input logic [W-1:0] d, input logic en);
    load = l; mode = md; data = d; enable = en;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_count = 0; m_reload = 0; m_mode = 0; m_running = 0; m_expire = 0;
  endtask

  task automatic model_step();
    m_expire = 0;
    if (load) begin
      m_count   = int'(data);
      m_reload  = int'(data);
      m_mode    = mode;
      m_running = (data != 0);
    end else if (enable && m_running) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_expire = 1;
        if (m_mode) m_count = m_reload;
        else        m_running = 0;
      end
    end
  endtask

  task automatic check_model(input string name);
    check(name, {count, expire, busy, zero},
          {m_count[W-1:0], m_expire, m_running, (m_count == 0)});
  endtask

  initial begin
    int n;
    bit seen_zero;
    bit seen_expire;

    rst = 1'b1;
    drive(0, 0, '0, 0);
    #12;
    check("reset_state", {count, expire, busy, zero}, {8'h00, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;
    tick();
    check("idle_after_reset", {count, busy, zero}, {8'h00, 1'b0, 1'b1});

    // Asynchronous reset mid-cycle while Count = 0x23.
    drive(1, 0, 8'h23, 0);
    tick();
    drive(0, 0, '0, 0);
    check("load_23", count, 8'h23);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {count, expire, busy, zero}, {8'h00, 1'b0, 1'b0, 1'b1});
    tick();
    rst = 1'b0;

    // Vector table, applied sequentially from the reset state.
    vecs.push_back('{1, 0, 8'd3,  0, 8'd3,  0, 1, 0});
    vecs.push_back('{0, 0, 8'd0,  1, 8'd2,  0, 1, 0});
    vecs.push_back('{0, 0, 8'd0,  1, 8'd1,  0, 1, 0});
    vecs.push_back('{0, 0, 8'd0,  0, 8'd1,  0, 1, 0});
    vecs.push_back('{0, 0, 8'd0,  1, 8'd0,  1, 0, 1});
    vecs.push_back('{0, 0, 8'd0,  1, 8'd0,  0, 0, 1});
    vecs.push_back('{1, 1, 8'd0,  1, 8'd0,  0, 0, 1});
    vecs.push_back('{1, 1, 8'd2,  0, 8'd2,  0, 1, 0});
    vecs.push_back('{0, 0, 8'd0,  1, 8'd1,  0, 1, 0});
    vecs.push_back('{0, 0, 8'd0,  1, 8'd2,  1, 1, 0});
    vecs.push_back('{0, 0, 8'd0,  1, 8'd1,  0, 1, 0});
    vecs.push_back('{0, 0, 8'd0,  1, 8'd2,  1, 1, 0});
    vecs.push_back('{0, 0, 8'd0,  1, 8'd1,  0, 1, 0});
    vecs.push_back('{1, 0, 8'h10, 1, 8'h10, 0, 1, 0});
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, vecs[i].mode, vecs[i].data, vecs[i].enable);
      tick();
      check($sformatf("vec%0d", i), {count, expire, busy, zero},
            {vecs[i].exp_count, vecs[i].exp_expire, vecs[i].exp_busy, vecs[i].exp_zero});
    end

    // One-shot from 5, then saturation at 0.
    drive(1, 0, 8'd5, 0);
    tick();
    check("os_load", {count, busy}, {8'd5, 1'b1});
    drive(0, 0, '0, 1);
    for (int i = 4; i >= 0; i--) begin
      tick();
      check($sformatf("os_cnt%0d", i), {count, expire, busy},
            {W'(i), (i == 0), (i != 0)});
    end
    seen_expire = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (expire || count != 0) seen_expire = 1;
    end
    check("os_saturate", {count, seen_expire}, {8'd0, 1'b0});

    // Auto-reload with period 3; zero must never appear.
    drive(1, 1, 8'd3, 1);
    tick();
    drive(0, 0, '0, 1);
    seen_zero = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (zero) seen_zero = 1;
      check($sformatf("ar_%0d", i), {count, expire},
            {W'(3 - ((i + 1) % 3)), ((i + 1) % 3 == 0)});
    end
    check("ar_no_zero", seen_zero, 1'b0);

    // Pause: remaining count survives disabled cycles.
    drive(1, 0, 8'd4, 0);
    tick();
    drive(0, 0, '0, 1);
    tick();
    tick();
    check("pause_pre", count, 8'd2);
    drive(0, 0, '0, 0);
    seen_expire = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (expire || count != 2) seen_expire = 1;
    end
    check("pause_hold", seen_expire, 1'b0);
    drive(0, 0, '0, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!expire && n < 10);
    check("pause_resume_cycles", n, 2);

    // 0xFF one-shot: 255 enabled cycles to expiry.
    drive(1, 0, 8'hFF, 0);
    tick();
    drive(0, 0, '0, 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!expire && n < 300);
    check("ff_cycles", n, 255);
    check("ff_end", {count, busy, zero}, {8'd0, 1'b0, 1'b1});

    // Reload of 1: expiry on every enabled cycle.
    drive(1, 1, 8'd1, 0);
    tick();
    drive(0, 0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("r1_%0d", i), {count, expire, busy}, {8'd1, 1'b1, 1'b1});
    end

    // Randomized run against the behavioural model.
    drive(0, 0, '0, 0);
    do_reset();
    check_model("rand_reset");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        check_model("rand_async_reset");
      end
      load   = ($urandom_range(0, 15) == 0);
      mode   = $urandom_range(0, 1);
      data   = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 6));
      enable = ($urandom_range(0, 3) != 0);
      model_step();
      tick();
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
- Loadable 8-bit down counter/timer; the count-down counterpart of the team's 8-bit up counter.
- Counts a loaded value down to terminal count on enabled cycles.
- Flags expiry with a one-cycle pulse.
- Supports one-shot or auto-reload (periodic) operation, for timeouts and periodic ticks.

Parameters:
- WIDTH, 8, counter, data and reload register width.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  count-down enable.
- Load  input  1  synchronous load of Data into the count and reload registers.
- Mode  input  1  sampled only with Load: 0 = one-shot, 1 = auto-reload.
- Data  input  WIDTH  load value.
- Count  output  WIDTH  current count, registered.
- Zero  output  1  high when Count == 0, combinational from Count.
- Expire  output  1  one-cycle pulse on terminal count, registered.
- Busy  output  1  high while in state RUN.

Behaviour:
- One clock; reset is asynchronous and active-high. Reset immediately forces:
  - Count = 0, internal Reload = 0, Mode_q = 0, state IDLE;
  - Expire = 0, Busy = 0, Zero = 1.
- Reset mid-count aborts the count with no Expire. The first edge after Reset deasserts behaves as in IDLE.
- States:
  - IDLE: count holds.
  - RUN: counting.
- Priority at each edge: Reset > Load > Enable > hold.
- Load = 1 (either state):
  - Count <= Data, Reload <= Data, Mode_q <= Mode, Expire <= 0.
  - Next state is RUN if Data != 0, else IDLE.
  - Load overrides a coincident terminal count, so no Expire is produced.
- RUN, Enable = 1, Count > 1: Count <= Count - 1, Expire <= 0.
- RUN, Enable = 1, Count == 1 (terminal count): Expire <= 1 for exactly one cycle, then:
  - Mode_q = 0: Count <= 0, next state IDLE, Busy falls with Count showing 0.
  - Mode_q = 1: Count <= Reload, stay in RUN. Period = Reload enabled cycles; Count never shows 0.
- RUN, Enable = 0: Count holds, Expire <= 0. Pausing any number of cycles does not change the remaining count.
- IDLE with Enable = 1: Count holds at its value (0 after expiry). No wrap to 0xFF; the counter saturates at 0.
- Latency:
  - Count and Expire update on the same edge.
  - Expire is high in the cycle where Count first shows the terminal result.
- Boundary cases:
  - Reload = 1 in auto-reload: Expire is high on every enabled cycle; Count stays 1.
  - Data = 0 on Load: IDLE, Zero = 1, no Expire.
  - Data = 0xFF: 255 enabled cycles to expiry.
- Mode changes without Load are ignored.

Decomposition:
- Shared package/include (counter_defs): WIDTH default, state encoding constants (ST_IDLE, ST_RUN), mode constants (MODE_ONESHOT, MODE_RELOAD). The up counter shares the WIDTH default.
- Single module; no sub-module is warranted. The next-count mux and terminal detect stay inline.

Test Plan:
1. Async reset: assert Reset mid-cycle while Count = 0x23 -> Count = 0x00, Zero = 1, Busy = 0, Expire = 0 immediately, without a clock edge.
2. One-shot: Load Data = 0x05, Mode = 0, then Enable = 1 -> Count 5,4,3,2,1,0. Expire high only in the cycle Count = 0; Busy falls there. Count holds 0 for a further 10 enabled cycles.
3. Auto-reload: Load Data = 0x03, Mode = 1, Enable held high -> Count 3,2,1,3,2,1,... Expire high every 3rd cycle (each time Count shows 3 after 1). Zero is never asserted.
4. Pause: Load 0x04, enable 2 cycles (Count = 2), Enable = 0 for 5 cycles (Count holds 2, Expire = 0), re-enable -> Expire exactly 2 enabled cycles later.
5. Load collision: in RUN with Count = 0x01 and Enable = 1, also assert Load with Data = 0x10 -> Count = 0x10, Expire stays 0, Busy = 1.
6. Edge values:
   - Load 0x00 -> IDLE, Zero = 1, no Expire.
   - Load 0xFF, Mode = 0, Enable held -> Expire exactly 255 cycles later.
   - Load 0x01, Mode = 1 -> Expire every enabled cycle.
